// File: rtl/filtro_vizinhos_pkg.sv
// Shared constants and FSM encoding for the neighbour filter stage.
package filtro_vizinhos_pkg;

  localparam int unsigned NUM_VIZINHOS   = 8;
  localparam int unsigned NUM_PORTAS_EST = 9;
  localparam int unsigned IDX_WIDTH      = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONSULTA = 2'd1,
    ST_EMITE    = 2'd2,
    ST_FIM      = 2'd3
  } estado_t;

endpackage

// File: rtl/codificador_prioridade_8.sv
// Lowest-set-bit priority encoder over the pending-neighbour mask.
module codificador_prioridade_8
  import filtro_vizinhos_pkg::*;
(
  input  logic [NUM_VIZINHOS-1:0] i_mask,
  output logic [IDX_WIDTH-1:0]    o_idx,
  output logic                    o_any
);

  always_comb begin
    o_idx = '0;
    for (int k = int'(NUM_VIZINHOS) - 1; k >= 0; k--) begin
      if (i_mask[k]) o_idx = IDX_WIDTH'(k);
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/filtro_vizinhos.sv
// Drops established neighbours and self-loops, marks the expanded node
// established and streams the survivors one per handshake.
module filtro_vizinhos
  import filtro_vizinhos_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned PESO_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid_in,
  output logic                                 in_ready_out,
  input  logic [ADDR_WIDTH-1:0]                atual_addr_in,
  input  logic [NUM_VIZINHOS*ADDR_WIDTH-1:0]   vizinhos_addr_in,
  input  logic [NUM_VIZINHOS*PESO_WIDTH-1:0]   vizinhos_peso_in,
  input  logic [NUM_VIZINHOS-1:0]              vizinhos_mask_in,
  output logic [NUM_PORTAS_EST*ADDR_WIDTH-1:0] est_read_addr_out,
  input  logic [NUM_PORTAS_EST-1:0]            est_read_data_in,
  output logic                                 est_write_en_out,
  output logic [ADDR_WIDTH-1:0]                est_write_addr_out,
  output logic                                 est_write_data_out,
  output logic                                 out_valid_out,
  input  logic                                 out_ready_in,
  output logic [ADDR_WIDTH-1:0]                out_addr_out,
  output logic [PESO_WIDTH-1:0]                out_peso_out,
  output logic [ADDR_WIDTH-1:0]                out_pai_out,
  output logic                                 done_out,
  output logic                                 descartado_out
);

  estado_t                            r_estado;
  logic [ADDR_WIDTH-1:0]              r_atual;
  logic [NUM_VIZINHOS*ADDR_WIDTH-1:0] r_viz_addr;
  logic [NUM_VIZINHOS*PESO_WIDTH-1:0] r_viz_peso;
  logic [NUM_VIZINHOS-1:0]            r_pend;
  logic [IDX_WIDTH-1:0]               r_idx;
  logic                               r_in_ready;
  logic                               r_out_valid;
  logic [ADDR_WIDTH-1:0]              r_out_addr;
  logic [PESO_WIDTH-1:0]              r_out_peso;
  logic [ADDR_WIDTH-1:0]              r_out_pai;
  logic                               r_done;
  logic                               r_descartado;

  logic [ADDR_WIDTH-1:0]   w_viz_addr [NUM_VIZINHOS];
  logic [PESO_WIDTH-1:0]   w_viz_peso [NUM_VIZINHOS];
  logic [NUM_VIZINHOS-1:0] w_auto;
  logic [NUM_VIZINHOS-1:0] w_pend_ini;
  logic [NUM_VIZINHOS-1:0] w_cod_in;
  logic [IDX_WIDTH-1:0]    w_idx;
  logic                    w_any;
  logic                    w_write_en;

  // Unpack neighbour slots and flag self-loops.
  always_comb begin
    w_auto = '0;
    for (int k = 0; k < int'(NUM_VIZINHOS); k++) begin
      w_viz_addr[k] = r_viz_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_viz_peso[k] = r_viz_peso[k*PESO_WIDTH +: PESO_WIDTH];
      w_auto[k]     = (w_viz_addr[k] == r_atual);
    end
  end

  // In CONSULTA r_pend still holds the raw mask.
  assign w_pend_ini = r_pend & ~est_read_data_in[NUM_PORTAS_EST-1:1] & ~w_auto;
  assign w_cod_in   = (r_estado == ST_CONSULTA) ? w_pend_ini : r_pend;
  assign w_write_en = (r_estado == ST_CONSULTA) && !est_read_data_in[0];

  codificador_prioridade_8 u_cod (
    .i_mask (w_cod_in),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado     <= ST_IDLE;
      r_atual      <= '0;
      r_viz_addr   <= '0;
      r_viz_peso   <= '0;
      r_pend       <= '0;
      r_idx        <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_peso   <= '0;
      r_out_pai    <= '0;
      r_done       <= 1'b0;
      r_descartado <= 1'b0;
    end else begin
      case (r_estado)
        ST_IDLE: begin
          if (r_in_ready && in_valid_in) begin
            r_atual    <= atual_addr_in;
            r_viz_addr <= vizinhos_addr_in;
            r_viz_peso <= vizinhos_peso_in;
            r_pend     <= vizinhos_mask_in;
            r_in_ready <= 1'b0;
            r_estado   <= ST_CONSULTA;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_CONSULTA: begin
          if (est_read_data_in[0]) begin
            r_pend       <= '0;
            r_descartado <= 1'b1;
            r_done       <= 1'b1;
            r_estado     <= ST_FIM;
          end else if (w_any) begin
            r_pend      <= w_pend_ini;
            r_idx       <= w_idx;
            r_out_addr  <= w_viz_addr[w_idx];
            r_out_peso  <= w_viz_peso[w_idx];
            r_out_pai   <= r_atual;
            r_out_valid <= 1'b1;
            r_estado    <= ST_EMITE;
          end else begin
            r_pend   <= '0;
            r_done   <= 1'b1;
            r_estado <= ST_FIM;
          end
        end
        ST_EMITE: begin
          // Each handshake is followed by one cycle that loads the next slot.
          if (r_out_valid) begin
            if (out_ready_in) begin
              r_pend[r_idx] <= 1'b0;
              r_out_valid   <= 1'b0;
            end
          end else if (w_any) begin
            r_idx       <= w_idx;
            r_out_addr  <= w_viz_addr[w_idx];
            r_out_peso  <= w_viz_peso[w_idx];
            r_out_pai   <= r_atual;
            r_out_valid <= 1'b1;
          end else begin
            r_done   <= 1'b1;
            r_estado <= ST_FIM;
          end
        end
        ST_FIM: begin
          r_done       <= 1'b0;
          r_descartado <= 1'b0;
          r_in_ready   <= 1'b1;
          r_estado     <= ST_IDLE;
        end
        default: r_estado <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_out       = r_in_ready;
  assign est_read_addr_out  = {r_viz_addr, r_atual};
  assign est_write_en_out   = w_write_en;
  assign est_write_addr_out = r_atual;
  assign est_write_data_out = w_write_en;
  assign out_valid_out      = r_out_valid;
  assign out_addr_out       = r_out_addr;
  assign out_peso_out       = r_out_peso;
  assign out_pai_out        = r_out_pai;
  assign done_out           = r_done;
  assign descartado_out     = r_descartado;

endmodule

// File: tb/tb_filtro_vizinhos.sv
// Directed bench for filtro_vizinhos with a behavioural established-node memory.
module tb_filtro_vizinhos;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_in;
  logic         in_ready_out;
  logic [7:0]   atual_addr_in;
  logic [63:0]  vizinhos_addr_in;
  logic [127:0] vizinhos_peso_in;
  logic [7:0]   vizinhos_mask_in;
  logic [71:0]  est_read_addr_out;
  logic [8:0]   est_read_data_in;
  logic         est_write_en_out;
  logic [7:0]   est_write_addr_out;
  logic         est_write_data_out;
  logic         out_valid_out;
  logic         out_ready_in;
  logic [7:0]   out_addr_out;
  logic [15:0]  out_peso_out;
  logic [7:0]   out_pai_out;
  logic         done_out;
  logic         descartado_out;

  filtro_vizinhos #(.ADDR_WIDTH(8), .PESO_WIDTH(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid_in        (in_valid_in),
    .in_ready_out       (in_ready_out),
    .atual_addr_in      (atual_addr_in),
    .vizinhos_addr_in   (vizinhos_addr_in),
    .vizinhos_peso_in   (vizinhos_peso_in),
    .vizinhos_mask_in   (vizinhos_mask_in),
    .est_read_addr_out  (est_read_addr_out),
    .est_read_data_in   (est_read_data_in),
    .est_write_en_out   (est_write_en_out),
    .est_write_addr_out (est_write_addr_out),
    .est_write_data_out (est_write_data_out),
    .out_valid_out      (out_valid_out),
    .out_ready_in       (out_ready_in),
    .out_addr_out       (out_addr_out),
    .out_peso_out       (out_peso_out),
    .out_pai_out        (out_pai_out),
    .done_out           (done_out),
    .descartado_out     (descartado_out)
  );

  always #5 clk = ~clk;

  // Established-node memory: combinational reads, clocked writes.
  bit [255:0] mem;
  logic       mem_clr;
  logic       mem_set_en;
  logic [7:0] mem_set_addr;

  always @(posedge clk) begin
    if (mem_clr) mem <= '0;
    else begin
      if (mem_set_en) mem[mem_set_addr] <= 1'b1;
      if (est_write_en_out) mem[est_write_addr_out] <= est_write_data_out;
    end
  end

  always_comb begin
    est_read_data_in = '0;
    for (int s = 0; s < 9; s++) est_read_data_in[s] = mem[est_read_addr_out[s*8 +: 8]];
  end

  int n_checks = 0;
  int n_err = 0;
  int ciclo;
  int n_write;
  int wr_ciclo;
  int done_ciclo;
  logic [7:0]  wr_addr;
  logic        wr_data;
  logic        done_desc;
  logic        timeout;
  logic [7:0]  em_addr [$];
  logic [15:0] em_peso [$];
  logic [7:0]  em_pai  [$];
  int          em_ciclo[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prep_mem(input logic set_en, input logic [7:0] set_addr);
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    if (set_en) begin
      mem_set_en = 1'b1;
      mem_set_addr = set_addr;
      @(posedge clk); #1;
      mem_set_en = 1'b0;
    end
  endtask

  // Presents a descriptor and returns at T0+1.
  task automatic enviar(input logic [7:0] atual, input logic [63:0] addrs,
                        input logic [127:0] pesos, input logic [7:0] mask);
    int espera;
    espera = 0;
    while (!in_ready_out && espera < 20) begin
      @(posedge clk); #1;
      espera++;
    end
    check("aceite_pronto", 32'(in_ready_out), 32'd1);
    atual_addr_in = atual;
    vizinhos_addr_in = addrs;
    vizinhos_peso_in = pesos;
    vizinhos_mask_in = mask;
    in_valid_in = 1'b1;
    @(posedge clk); #1;
    in_valid_in = 1'b0;
    n_write = 0; wr_ciclo = -1; done_ciclo = -1;
    em_addr.delete(); em_peso.delete(); em_pai.delete(); em_ciclo.delete();
    ciclo = 1;
  endtask

  // Records writes, handshakes and done until done_out, bounded.
  task automatic coletar();
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (est_write_en_out) begin
        n_write++; wr_addr = est_write_addr_out; wr_data = est_write_data_out; wr_ciclo = ciclo;
      end
      if (out_valid_out && out_ready_in) begin
        em_addr.push_back(out_addr_out); em_peso.push_back(out_peso_out);
        em_pai.push_back(out_pai_out); em_ciclo.push_back(ciclo);
      end
      if (done_out) begin
        done_ciclo = ciclo; done_desc = descartado_out; timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      ciclo++;
    end
    check("timeout_done", 32'(timeout), 32'd0);
  endtask

  task automatic check_emit(input int i, input logic [7:0] a, input logic [15:0] p,
                            input logic [7:0] pai, input int cyc);
    check($sformatf("emit%0d_addr", i), 32'(em_addr[i]), 32'(a));
    check($sformatf("emit%0d_peso", i), 32'(em_peso[i]), 32'(p));
    check($sformatf("emit%0d_pai", i), 32'(em_pai[i]), 32'(pai));
    check($sformatf("emit%0d_ciclo", i), 32'(em_ciclo[i]), 32'(cyc));
  endtask

  task automatic check_fim(input int dcyc, input logic desc, input int nw, input int ne);
    check("done_ciclo", 32'(done_ciclo), 32'(dcyc));
    check("descartado", 32'(done_desc), 32'(desc));
    check("n_write", 32'(n_write), 32'(nw));
    check("n_emit", 32'(em_addr.size()), 32'(ne));
  endtask

  initial begin
    int vistos;
    rst_n = 1'b0;
    in_valid_in = 1'b0;
    atual_addr_in = '0;
    vizinhos_addr_in = '0;
    vizinhos_peso_in = '0;
    vizinhos_mask_in = '0;
    out_ready_in = 1'b1;
    mem_clr = 1'b1;
    mem_set_en = 1'b0;
    mem_set_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready_out), 32'd0);
    check("rst_out_valid", 32'(out_valid_out), 32'd0);
    check("rst_write_en", 32'(est_write_en_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_read_addr", 32'(est_read_addr_out[31:0]), 32'd0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("pos_rst_in_ready", 32'(in_ready_out), 32'd1);

    // Three clean neighbours.
    enviar(8'd5, {40'd0, 8'd12, 8'd11, 8'd10}, {80'd0, 16'd9, 16'd4, 16'd3}, 8'b0000_0111);
    check("t1_read_slot0", 32'(est_read_addr_out[7:0]), 32'd5);
    check("t1_read_slot3", 32'(est_read_addr_out[31:24]), 32'd12);
    coletar();
    check_fim(8, 1'b0, 1, 3);
    check("t1_wr_addr", 32'(wr_addr), 32'd5);
    check("t1_wr_data", 32'(wr_data), 32'd1);
    check("t1_wr_ciclo", 32'(wr_ciclo), 32'd1);
    check_emit(0, 8'd10, 16'd3, 8'd5, 2);
    check_emit(1, 8'd11, 16'd4, 8'd5, 4);
    check_emit(2, 8'd12, 16'd9, 8'd5, 6);
    @(posedge clk); #1;
    check("t1_ready_apos_done", 32'(in_ready_out), 32'd1);
    check("t1_mem5", 32'(mem[5]), 32'd1);

    // Node 11 already established.
    prep_mem(1'b1, 8'd11);
    enviar(8'd5, {40'd0, 8'd12, 8'd11, 8'd10}, {80'd0, 16'd9, 16'd4, 16'd3}, 8'b0000_0111);
    coletar();
    check_fim(6, 1'b0, 1, 2);
    check_emit(0, 8'd10, 16'd3, 8'd5, 2);
    check_emit(1, 8'd12, 16'd9, 8'd5, 4);

    // Current node already established.
    prep_mem(1'b1, 8'd5);
    enviar(8'd5, {40'd0, 8'd12, 8'd11, 8'd10}, {80'd0, 16'd9, 16'd4, 16'd3}, 8'b0000_0111);
    coletar();
    check_fim(2, 1'b1, 0, 0);

    // Empty mask.
    prep_mem(1'b0, 8'd0);
    enviar(8'd5, {40'd0, 8'd12, 8'd11, 8'd10}, {80'd0, 16'd9, 16'd4, 16'd3}, 8'h00);
    coletar();
    check_fim(2, 1'b0, 1, 0);
    check("t4_wr_ciclo", 32'(wr_ciclo), 32'd1);

    // Self-loop in slot 0 is dropped.
    prep_mem(1'b0, 8'd0);
    enviar(8'd7, {48'd0, 8'd30, 8'd7}, {96'd0, 16'd50, 16'd1}, 8'b0000_0011);
    coletar();
    check_fim(4, 1'b0, 1, 1);
    check_emit(0, 8'd30, 16'd50, 8'd7, 2);

    // Backpressure on the first emission for four cycles.
    prep_mem(1'b0, 8'd0);
    out_ready_in = 1'b0;
    enviar(8'd5, {40'd0, 8'd12, 8'd11, 8'd10}, {80'd0, 16'd9, 16'd4, 16'd3}, 8'b0000_0111);
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", c), 32'(out_valid_out), 32'd1);
      check($sformatf("bp_addr_c%0d", c), 32'(out_addr_out), 32'd10);
      check($sformatf("bp_peso_c%0d", c), 32'(out_peso_out), 32'd3);
    end
    @(posedge clk); #1;
    out_ready_in = 1'b1;
    ciclo = 6;
    coletar();
    check_fim(12, 1'b0, 0, 3);
    check_emit(0, 8'd10, 16'd3, 8'd5, 6);
    check_emit(1, 8'd11, 16'd4, 8'd5, 8);
    check_emit(2, 8'd12, 16'd9, 8'd5, 10);

    // Reset while two neighbours are pending.
    prep_mem(1'b0, 8'd0);
    out_ready_in = 1'b0;
    enviar(8'd5, {48'd0, 8'd21, 8'd20}, {96'd0, 16'd2, 16'd1}, 8'b0000_0011);
    @(posedge clk); #1;
    check("rst_mid_valid_antes", 32'(out_valid_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid_out), 32'd0);
    check("rst_mid_addr", 32'(out_addr_out), 32'd0);
    check("rst_mid_pai", 32'(out_pai_out), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready_out), 32'd0);
    check("rst_mid_write_en", 32'(est_write_en_out), 32'd0);
    check("rst_mid_read_addr", 32'(est_read_addr_out[31:0]), 32'd0);
    out_ready_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_in_ready", 32'(in_ready_out), 32'd1);
    vistos = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid_out || est_write_en_out || done_out) vistos++;
      @(posedge clk); #1;
    end
    check("rst_sem_residuo", 32'(vistos), 32'd0);
    check("rst_mem5", 32'(mem[5]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/filtro_vizinhos.md
Name: filtro_vizinhos

Overview:
- Stage directly upstream of gerenciador_estabelecidos in the Dijkstra datapath.
- Accepts one expanded node (the current node) plus up to 8 neighbour addresses and edge weights.
- Queries the established-node memory on all 9 read ports in one cycle, then marks the current node established.
- Emits only the valid, not-yet-established neighbours, one per handshake, toward the relaxation/priority-queue stage.

Parameters:
- ADDR_WIDTH, 8: node address width; must match gerenciador_estabelecidos.
- PESO_WIDTH, 16: edge weight width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_in  in  1  node descriptor valid.
- in_ready_out  out  1  block can accept a descriptor (high only in IDLE).
- atual_addr_in  in  ADDR_WIDTH  current node address.
- vizinhos_addr_in  in  8*ADDR_WIDTH  neighbour k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- vizinhos_peso_in  in  8*PESO_WIDTH  edge weight of neighbour k.
- vizinhos_mask_in  in  8  bit k = neighbour k present.
- est_read_addr_out  out  9*ADDR_WIDTH  slot 0 = current node, slots 1..8 = neighbours 0..7; drives read_addr0..8 of the memory.
- est_read_data_in  in  9  combinational read data from the memory, same slot order.
- est_write_en_out  out  1  write strobe to the memory.
- est_write_addr_out  out  ADDR_WIDTH  write address.
- est_write_data_out  out  1  write data (always 1 when strobed).
- out_valid_out  out  1  emitted neighbour valid.
- out_ready_in  in  1  downstream accepts.
- out_addr_out  out  ADDR_WIDTH  neighbour address.
- out_peso_out  out  PESO_WIDTH  edge weight.
- out_pai_out  out  ADDR_WIDTH  parent node, i.e. the current node.
- done_out  out  1  one-cycle pulse when the descriptor has been fully processed.
- descartado_out  out  1  qualifies done_out: the current node was already established.

Behaviour:
- Reset: all registered state and every output go to 0; the FSM enters IDLE. Reset asserted mid-operation aborts immediately: pending neighbours are lost and no write is issued after the reset edge.
- FSM state IDLE:
  - in_ready_out = 1.
  - On in_valid_in, register the address, weights and mask, then go to CONSULTA.
  - This is accept cycle T0.
- FSM state CONSULTA (T0+1):
  - est_read_addr_out is driven from the registered inputs.
  - Compute pend = mask & ~est_read_data_in[8:1] & ~(neighbour addr == atual), so self-loops are dropped.
  - If est_read_data_in[0] = 1: no write, set descartado, go to FIM.
  - Otherwise: est_write_en_out = 1 for this single cycle with est_write_addr_out = atual and est_write_data_out = 1.
  - Next state is EMITE if pend != 0, else FIM.
  - The reads in this cycle see pre-write memory contents.
- FSM state EMITE (first entry T0+2):
  - Select the lowest set index k of pend.
  - out_valid_out = 1; out_addr_out, out_peso_out and out_pai_out are registered and hold stable while out_ready_in is low.
  - On out_valid_out & out_ready_in: clear pend[k]. The next neighbour is presented the following cycle, giving at most 1 emission per 2 cycles.
  - When the last bit clears, go to FIM.
- FSM state FIM:
  - done_out = 1 for one cycle; descartado_out is valid in the same cycle.
  - Clear descartado, go to IDLE.
- Throughput:
  - Descriptor with N emissions and ready held high: done at T0+2+2N-1+1 when N > 0, or T0+2 when N = 0.
  - Next accept is one cycle after done.
- Duplicate neighbour addresses are each emitted; filtering them is downstream's responsibility.
- out_valid_out never drops without a handshake, except on reset.

Decomposition:
- Shared package:
  - NUM_VIZINHOS = 8.
  - NUM_PORTAS_EST = 9.
  - FSM state encoding (IDLE, CONSULTA, EMITE, FIM, 2 bits).
- Sub-module codificador_prioridade_8:
  - Combinational; input 8-bit mask.
  - Outputs a 3-bit lowest-set index and an any-set flag.

Test Plan:
- Memory all zero; atual=5, mask=8'b0000_0111, addrs 10/11/12, weights 3/4/9, ready=1 -> write (5,1) at T0+1; emissions (10,3,5), (11,4,5), (12,9,5); done with descartado=0.
- Memory holds node 11 established; same stimulus -> only 10 and 12 emitted; node 11 never appears at the output.
- Node 5 pre-established -> est_write_en_out stays 0, no out_valid_out, done+descartado at T0+2.
- mask=8'h00 -> write (5,1) at T0+1; done at T0+2; no emissions.
- out_ready_in held low for 4 cycles during the first emission -> out_addr_out and out_peso_out stable and valid held throughout; no bit cleared; sequence then completes normally.
- Reset asserted during EMITE with 2 neighbours pending -> all outputs 0 asynchronously; after release in_ready_out=1 and no stale emission appears.
